// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq; the slave side is the multiplier.
// dbg_state mirrors the multiplier FSM so external checkers can follow it.
interface fp_mul_seq_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int FP_W = 1 + EXP_W + MAN_W;

   // A transfer happens on a rising edge where valid && ready; the producer holds
   // its payload stable from valid rising until that edge, and ready never waits on valid.
   logic            in_valid;
   logic            in_ready;
   logic [FP_W-1:0] in_a;
   logic [FP_W-1:0] in_b;
   logic            out_valid;
   logic            out_ready;
   logic [FP_W-1:0] out_result;
   logic [1:0]      out_exc;
   logic [1:0]      dbg_state;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_exc, dbg_state
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_exc, dbg_state
   );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle floating-point multiplier: radix-4 Booth mantissa product, one step per clock.
// Define ROUND_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   fp_mul_seq_if.slave bus
);
   localparam int FP_W   = 1 + EXP_W + MAN_W;
   localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
   localparam int N_ITER = (MAN_W + 3) / 2;
   localparam int MC_W   = MAN_W + 3;
   localparam int ACC_W  = MAN_W + 5;
   localparam int Q_W    = 2 * N_ITER + 1;
   localparam int LO_W   = Q_W - 1;
   localparam int PROD_W = 2 * MAN_W + 2;
   localparam int HI_W   = PROD_W - LO_W;
   localparam int E_W    = EXP_W + 2;
   localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   localparam logic signed [E_W-1:0] BIAS_S  = E_W'(BIAS);
   localparam logic signed [E_W-1:0] OVF_LIM = E_W'((1 << EXP_W) - 1);
   localparam logic signed [E_W-1:0] EXP_ONE = E_W'(1);
   localparam logic [FP_W-1:0]       QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;
   typedef enum logic [1:0] {C_NUM, C_ZERO, C_INV} cls_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   cls_t                    r_cls;
   logic                    r_sign;
   logic [EXP_W-1:0]        r_ea;
   logic [EXP_W-1:0]        r_eb;
   logic [MC_W-1:0]         r_mcand;
   logic signed [ACC_W-1:0] r_acc;
   logic [Q_W-1:0]          r_q;
   logic [FP_W-1:0]         r_res;
   logic [1:0]              r_res_exc;
   logic                    r_out_valid;
   logic [FP_W-1:0]         r_out_result;
   logic [1:0]              r_out_exc;

   // Operand classification at acceptance
   logic [EXP_W-1:0] w_a_exp, w_b_exp;
   logic [MAN_W-1:0] w_a_frac, w_b_frac;
   logic             w_a_special, w_b_special, w_a_den, w_b_den, w_a_zero, w_b_zero;
   cls_t             w_cls;

   assign w_a_exp     = bus.in_a[FP_W-2 -: EXP_W];
   assign w_b_exp     = bus.in_b[FP_W-2 -: EXP_W];
   assign w_a_frac    = bus.in_a[MAN_W-1:0];
   assign w_b_frac    = bus.in_b[MAN_W-1:0];
   assign w_a_special = &w_a_exp;
   assign w_b_special = &w_b_exp;
   assign w_a_den     = (w_a_exp == '0) && (w_a_frac != '0);
   assign w_b_den     = (w_b_exp == '0) && (w_b_frac != '0);
   assign w_a_zero    = (w_a_exp == '0) && (w_a_frac == '0);
   assign w_b_zero    = (w_b_exp == '0) && (w_b_frac == '0);

   always_comb begin
      w_cls = C_NUM;
      if (w_a_special || w_b_special || w_a_den || w_b_den) w_cls = C_INV;
      else if (w_a_zero || w_b_zero)                         w_cls = C_ZERO;
   end

   // Booth step: r_q[0] holds the previously scanned multiplier bit
   logic signed [ACC_W-1:0] w_m_ext, w_pp, w_sum;
   assign w_m_ext = $signed({{(ACC_W-MC_W){1'b0}}, r_mcand});

   always_comb begin
      w_pp = '0;
      case (r_q[2:0])
         3'b001, 3'b010: w_pp = w_m_ext;
         3'b011:         w_pp = w_m_ext <<< 1;
         3'b100:         w_pp = -(w_m_ext <<< 1);
         3'b101, 3'b110: w_pp = -w_m_ext;
         default:        w_pp = '0;
      endcase
   end

   assign w_sum = r_acc + w_pp;

   // Normalisation of the finished product
   logic [PROD_W-1:0]       w_prod;
   logic                    w_msb;
   logic [MAN_W-1:0]        w_frac_n, w_frac_r;
   logic signed [E_W-1:0]   w_exp_base, w_exp_r;
   logic                    w_unused;

   assign w_prod     = {r_acc[HI_W-1:0], r_q[Q_W-1:1]};
   assign w_msb      = w_prod[PROD_W-1];
   assign w_frac_n   = w_msb ? w_prod[2*MAN_W -: MAN_W] : w_prod[2*MAN_W-1 -: MAN_W];
   assign w_exp_base = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - BIAS_S
                     + $signed({{(E_W-1){1'b0}}, w_msb});

`ifdef ROUND_RNE_EN
   logic             w_guard, w_sticky, w_rnd_up;
   logic [MAN_W:0]   w_frac_inc;

   assign w_guard    = w_msb ? w_prod[MAN_W] : w_prod[MAN_W-1];
   assign w_sticky   = w_msb ? (|w_prod[MAN_W-1:0]) : (|w_prod[MAN_W-2:0]);
   assign w_rnd_up   = w_guard & (w_sticky | w_frac_n[0]);
   assign w_frac_inc = {1'b0, w_frac_n} + {{MAN_W{1'b0}}, w_rnd_up};
   // A carry out of the fraction leaves frac=0 and bumps the exponent
   assign w_frac_r   = w_frac_inc[MAN_W-1:0];
   assign w_exp_r    = w_exp_base + $signed({{(E_W-1){1'b0}}, w_frac_inc[MAN_W]});
   assign w_unused   = &{1'b0, r_acc[ACC_W-1:HI_W], r_q[0]};
`else
   assign w_frac_r   = w_frac_n;
   assign w_exp_r    = w_exp_base;
   assign w_unused   = &{1'b0, r_acc[ACC_W-1:HI_W], r_q[0], w_prod[MAN_W-1:0]};
`endif

   logic [FP_W-1:0] w_res;
   logic [1:0]      w_exc;

   always_comb begin
      w_res = '0;
      w_exc = 2'b00;
      if (r_cls == C_INV) begin
         w_res = QNAN;
         w_exc = 2'b11;
      end else if (r_cls == C_ZERO) begin
         w_res = '0;
         w_exc = 2'b00;
      end else if (w_exp_r >= OVF_LIM) begin
         w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_exc = 2'b01;
      end else if (w_exp_r < EXP_ONE) begin
         w_res = {r_sign, {(FP_W-1){1'b0}}};
         w_exc = 2'b10;
      end else begin
         w_res = {r_sign, w_exp_r[EXP_W-1:0], w_frac_r};
         w_exc = 2'b00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_cls        <= C_NUM;
         r_sign       <= 1'b0;
         r_ea         <= '0;
         r_eb         <= '0;
         r_mcand      <= '0;
         r_acc        <= '0;
         r_q          <= '0;
         r_res        <= '0;
         r_res_exc    <= 2'b00;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_exc    <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_cls   <= w_cls;
                  r_sign  <= bus.in_a[FP_W-1] ^ bus.in_b[FP_W-1];
                  r_ea    <= w_a_exp;
                  r_eb    <= w_b_exp;
                  r_mcand <= {2'b00, 1'b1, w_a_frac};
                  r_acc   <= '0;
                  r_q     <= {{(Q_W-MAN_W-2){1'b0}}, 1'b1, w_b_frac, 1'b0};
                  r_cnt   <= '0;
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               r_acc <= w_sum >>> 2;
               r_q   <= {w_sum[1:0], r_q[Q_W-1:2]};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(N_ITER - 1)) r_state <= S_NORM;
            end
            S_NORM: begin
               r_res     <= w_res;
               r_res_exc <= w_exc;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               // First DONE cycle publishes; afterwards hold until the consumer takes it
               if (!r_out_valid) begin
                  r_out_valid  <= 1'b1;
                  r_out_result <= r_res;
                  r_out_exc    <= r_res_exc;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == S_IDLE);
   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_exc    = r_out_exc;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq (half precision): drivers push expected
// results into a queue, an independent monitor pops and compares on each output transfer.
module tb_fp_mul_seq;
   logic clk;
   logic rst;

   fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus ();

   fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int acc_cyc  = 0;

   logic [17:0] exp_q[$];

`ifdef ROUND_RNE_EN
   localparam logic [15:0] EXP_T1 = 16'h4A20;
`else
   localparam logic [15:0] EXP_T1 = 16'h4A1F;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Monitor: samples 2ns after the falling edge, well clear of the rising edge
   always begin
      logic [17:0] e;
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %h with nothing pending", bus.out_result);
         end else begin
            e = exp_q.pop_front();
            check("result", 32'(bus.out_result), 32'(e[17:2]));
            check("exc", 32'(bus.out_exc), 32'(e[1:0]));
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [1:0] ee, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         timeout_fail("in_ready_wait");
         return;
      end
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      if (push) exp_q.push_back({er, ee});
      @(negedge clk);
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
      // Scramble operands after acceptance; the result must not depend on them
      bus.in_a     = 16'($urandom_range(0, 65535));
      bus.in_b     = 16'($urandom_range(0, 65535));
   endtask

   task automatic wait_result();
      int n;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) timeout_fail("out_valid_wait");
      else check("latency", 32'(cyc - acc_cyc), 32'd8);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.out_valid) timeout_fail("out_valid_clear");
   endtask

   task automatic run(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] er, input logic [1:0] ee);
      issue(a, b, er, ee, 1'b1);
      wait_result();
      wait_drain();
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic [1:0]  e;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{16'h4100, 16'h44E6, EXP_T1,   2'b00};
      vecs[1]  = '{16'h4200, 16'h4200, 16'h4880, 2'b00};
      vecs[2]  = '{16'hC100, 16'h4400, 16'hC900, 2'b00};
      vecs[3]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 2'b01};
      vecs[4]  = '{16'h0500, 16'h0906, 16'h0000, 2'b10};
      vecs[5]  = '{16'h7C00, 16'h44E6, 16'h7E00, 2'b11};
      vecs[6]  = '{16'h0100, 16'h44E6, 16'h7E00, 2'b11};
      vecs[7]  = '{16'h0000, 16'h44E6, 16'h0000, 2'b00};
      vecs[8]  = '{16'h3C00, 16'h3C00, 16'h3C00, 2'b00};
      vecs[9]  = '{16'hBC00, 16'h3C00, 16'hBC00, 2'b00};
      vecs[10] = '{16'h8000, 16'h4000, 16'h0000, 2'b00};
      vecs[11] = '{16'h8500, 16'h0906, 16'h8000, 2'b10};
      vecs[12] = '{16'h7E00, 16'h0000, 16'h7E00, 2'b11};
      vecs[13] = '{16'h3C00, 16'h7BFF, 16'h7BFF, 2'b00};
      vecs[14] = '{16'h0400, 16'h3C00, 16'h0400, 2'b00};
      vecs[15] = '{16'h0400, 16'h3800, 16'h0000, 2'b10};
   end

   initial begin
      int n;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_result", 32'(bus.out_result), 32'd0);
      check("rst_out_exc", 32'(bus.out_exc), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'd0);

      foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);
      run(16'h3BFF, 16'h3BFF, 16'h3BFE, 2'b00);

      // Backpressure: result held, no acceptance, in_valid pulses ignored
      bus.out_ready = 1'b0;
      issue(16'h4200, 16'h4200, 16'h4880, 2'b00, 1'b1);
      wait_result();
      for (int k = 0; k < 5; k++) begin
         bus.in_a     = 16'h3C00;
         bus.in_b     = 16'h3C00;
         bus.in_valid = k[0];
         @(negedge clk);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_out_result", 32'(bus.out_result), 32'h4880);
         check("bp_out_exc", 32'(bus.out_exc), 32'd0);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      wait_drain();
      repeat (12) @(negedge clk);
      check("bp_no_extra", 32'(bus.out_valid), 32'd0);

      // Reset in the third MUL cycle aborts the operation
      issue(16'h4100, 16'h44E6, 16'h0000, 2'b00, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("mid_state_mul", 32'(bus.dbg_state), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_out_result", 32'(bus.out_result), 32'd0);
      check("abort_state", 32'(bus.dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      run(16'hC100, 16'h4400, 16'hC900, 2'b00);

      // Reset while a result is stalled in DONE clears it at once
      bus.out_ready = 1'b0;
      issue(16'h4200, 16'h4200, 16'h0000, 2'b00, 1'b0);
      wait_result();
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("done_abort_valid", 32'(bus.out_valid), 32'd0);
      check("done_abort_result", 32'(bus.out_result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      run(16'h4100, 16'h44E6, EXP_T1, 2'b00);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) timeout_fail("scoreboard_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
